// File: rtl/rca_arbiter.sv
// rca_arbiter: round-robin arbiter feeding one shared ripple-carry adder
// through a two-stage pipeline (operand register, then result register).
//
// Parameters:
//   BITS  - operand/sum width
//   N_REQ - number of requesters (2..8)
//   IDW   - requester ID width, derived from N_REQ
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   req_i             - level request per requester
//   a_i, b_i          - packed operands, requester k at [k*BITS +: BITS]
//   cin_i             - carry-in per requester
//   gnt_o             - one-hot combinational grant
//   res_valid_o       - result register holds a valid result
//   res_ready_i       - consumer accepts the result
//   res_sum_o         - registered sum
//   res_cout_o        - registered carry-out
//   res_id_o          - ID of the requester that produced the result
//   res_ovf_o         - registered signed overflow (only with RCA_ARB_OVF_EN)
//
// Optional feature macro: RCA_ARB_OVF_EN adds the res_ovf_o output.

// Plain ripple-carry adder built from a chain of full adders.
module RCA #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    input  logic            cin_i,
    output logic [BITS-1:0] sum_o,
    output logic            cout_o
);
    logic [BITS:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < BITS; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[BITS];
endmodule

module rca_arbiter #(
    parameter int  BITS  = 8,
    parameter int  N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ*BITS-1:0] a_i,
    input  logic [N_REQ*BITS-1:0] b_i,
    input  logic [N_REQ-1:0]      cin_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [BITS-1:0]       res_sum_o,
    output logic                  res_cout_o,
`ifdef RCA_ARB_OVF_EN
    output logic                  res_ovf_o,
`endif
    output logic [IDW-1:0]        res_id_o
);
    logic            adv;
    logic [IDW-1:0]  last_q, last_d;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic [BITS-1:0] sel_a, sel_b;
    logic            sel_cin;

    logic            s1_valid_q, s1_valid_d;
    logic [BITS-1:0] s1_a_q, s1_a_d;
    logic [BITS-1:0] s1_b_q, s1_b_d;
    logic            s1_cin_q, s1_cin_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;

    logic            res_valid_q, res_valid_d;
    logic [BITS-1:0] res_sum_q, res_sum_d;
    logic            res_cout_q, res_cout_d;
    logic [IDW-1:0]  res_id_q, res_id_d;

    logic [BITS-1:0] sum;
    logic            cout;

    // A held, unaccepted result freezes the whole pipeline.
    assign adv = !res_valid_q | res_ready_i;

    // Search starts just after the last winner and wraps, so the most
    // recent winner has the lowest priority next time.
    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IDW'((int'(last_q) + i) % N_REQ);
            if (!found && req_i[idx] && adv && !rst) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

    assign gnt_o = gnt;

    // One-hot operand mux driven by the grant vector.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_a   = a_i[k*BITS +: BITS];
                sel_b   = b_i[k*BITS +: BITS];
                sel_cin = cin_i[k];
            end
        end
    end

    // Next state of the pointer and both pipeline stages; everything
    // holds when the pipeline is not advancing.
    always_comb begin
        last_d      = last_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_cin_d    = s1_cin_q;
        s1_id_d     = s1_id_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_id_d    = res_id_q;
        if (|gnt) begin
            last_d = gnt_id;
        end
        if (adv) begin
            s1_valid_d  = |gnt;
            s1_a_d      = sel_a;
            s1_b_d      = sel_b;
            s1_cin_d    = sel_cin;
            s1_id_d     = gnt_id;
            res_valid_d = s1_valid_q;
            res_sum_d   = sum;
            res_cout_d  = cout;
            res_id_d    = s1_id_q;
        end
    end

    RCA #(.BITS(BITS)) u_rca (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .cin_i  (s1_cin_q),
        .sum_o  (sum),
        .cout_o (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= IDW'(N_REQ - 1);
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= '0;
        end else begin
            last_q      <= last_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cin_q    <= s1_cin_d;
            s1_id_q     <= s1_id_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_sum_o   = res_sum_q;
    assign res_cout_o  = res_cout_q;
    assign res_id_o    = res_id_q;

`ifdef RCA_ARB_OVF_EN
    logic res_ovf_q, res_ovf_d;

    // Signed overflow: operands agree in sign but the sum does not.
    always_comb begin
        res_ovf_d = res_ovf_q;
        if (adv) begin
            res_ovf_d = (s1_a_q[BITS-1] == s1_b_q[BITS-1]) &&
                        (sum[BITS-1] != s1_a_q[BITS-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_ovf_q <= 1'b0;
        end else begin
            res_ovf_q <= res_ovf_d;
        end
    end

    assign res_ovf_o = res_ovf_q;
`endif
endmodule

// File: tb/tb_rca_arbiter.sv
// tb_rca_arbiter: directed testbench for rca_arbiter (BITS=8, N_REQ=4).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after the edge, well away from the next edge.
module tb_rca_arbiter;
    localparam int BITS  = 8;
    localparam int N_REQ = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [N_REQ-1:0]      req_i;
    logic [N_REQ*BITS-1:0] a_i;
    logic [N_REQ*BITS-1:0] b_i;
    logic [N_REQ-1:0]      cin_i;
    logic [N_REQ-1:0]      gnt_o;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [BITS-1:0]       res_sum_o;
    logic                  res_cout_o;
    logic [IDW-1:0]        res_id_o;
`ifdef RCA_ARB_OVF_EN
    logic                  res_ovf_o;
`endif

    int checkCount = 0;
    int passCount  = 0;

    rca_arbiter #(.BITS(BITS), .N_REQ(N_REQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .gnt_o       (gnt_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_sum_o   (res_sum_o),
        .res_cout_o  (res_cout_o),
`ifdef RCA_ARB_OVF_EN
        .res_ovf_o   (res_ovf_o),
`endif
        .res_id_o    (res_id_o)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] req, input logic ready);
        req_i       = req;
        res_ready_i = ready;
        #1;
    endtask

    task automatic setOp(input int k, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input logic c);
        a_i[k*BITS +: BITS] = a;
        b_i[k*BITS +: BITS] = b;
        cin_i[k]            = c;
    endtask

    task automatic checkResult(input string tag, input logic [BITS-1:0] sum,
                               input logic cout, input logic [IDW-1:0] id);
        checkOutput({tag, "_valid"}, 32'(res_valid_o), 32'(1'b1));
        checkOutput({tag, "_sum"}, 32'(res_sum_o), 32'(sum));
        checkOutput({tag, "_cout"}, 32'(res_cout_o), 32'(cout));
        checkOutput({tag, "_id"}, 32'(res_id_o), 32'(id));
    endtask

    // Holds reset for two edges with every request high, so the grant
    // gating by rst is visible, then releases it.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        nextCycle();
        nextCycle();
        applyStimulus(4'b1111, 1'b1);
        checkOutput("rst_gnt", 32'(gnt_o), 32'(4'b0000));
        checkOutput("rst_valid", 32'(res_valid_o), 32'(1'b0));
        checkOutput("rst_sum", 32'(res_sum_o), 32'(8'h00));
        checkOutput("rst_cout", 32'(res_cout_o), 32'(1'b0));
        checkOutput("rst_id", 32'(res_id_o), 32'(2'd0));
        rst   = 1'b0;
        req_i = '0;
    endtask

    function automatic logic [BITS-1:0] rrSum(input int k);
        return 8'((k + 1) * 17 + (k % 2));
    endfunction

    initial begin
        rst         = 1'b1;
        req_i       = '0;
        a_i         = '0;
        b_i         = '0;
        cin_i       = '0;
        res_ready_i = 1'b1;

        // Reset, then a single request from requester 0.
        doReset();
        nextCycle();
        setOp(0, 8'h0F, 8'h01, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("single_gnt", 32'(gnt_o), 32'(4'b0001));
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("single_c1_gnt", 32'(gnt_o), 32'(4'b0000));
        checkOutput("single_c1_valid", 32'(res_valid_o), 32'(1'b0));
        nextCycle();
        checkResult("single", 8'h10, 1'b0, 2'd0);

        // Carry-out from requester 2.
        nextCycle();
        setOp(2, 8'hFF, 8'h01, 1'b1);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("carry_gnt", 32'(gnt_o), 32'(4'b0100));
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        nextCycle();
        checkResult("carry", 8'h01, 1'b1, 2'd2);

        // Round-robin with all four requests held for 8 cycles.
        doReset();
        for (int k = 0; k < N_REQ; k++) begin
            setOp(k, 8'(16 * (k + 1)), 8'(k + 1), 1'(k % 2));
        end
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            applyStimulus((c < 8) ? 4'b1111 : 4'b0000, 1'b1);
            if (c < 8) begin
                checkOutput($sformatf("rr_gnt_c%0d", c), 32'(gnt_o), 32'(4'b0001 << (c % 4)));
            end else begin
                checkOutput($sformatf("rr_gnt_c%0d", c), 32'(gnt_o), 32'(4'b0000));
            end
            if (c < 2) begin
                checkOutput($sformatf("rr_valid_c%0d", c), 32'(res_valid_o), 32'(1'b0));
            end else begin
                checkResult($sformatf("rr_c%0d", c), rrSum((c - 2) % 4), 1'b0, 2'((c - 2) % 4));
            end
        end

        // Backpressure: two back-to-back grants, then a three-cycle stall
        // with requester 2 waiting.
        doReset();
        setOp(0, 8'h01, 8'h02, 1'b0);
        setOp(1, 8'h10, 8'h20, 1'b0);
        setOp(2, 8'h05, 8'h05, 1'b0);
        nextCycle();
        applyStimulus(4'b0011, 1'b1);
        checkOutput("bp_gnt0", 32'(gnt_o), 32'(4'b0001));
        nextCycle();
        applyStimulus(4'b0010, 1'b1);
        checkOutput("bp_gnt1", 32'(gnt_o), 32'(4'b0010));
        for (int s = 0; s < 3; s++) begin
            nextCycle();
            applyStimulus(4'b0100, 1'b0);
            checkOutput($sformatf("bp_stall%0d_gnt", s), 32'(gnt_o), 32'(4'b0000));
            checkResult($sformatf("bp_stall%0d", s), 8'h03, 1'b0, 2'd0);
        end
        nextCycle();
        applyStimulus(4'b0100, 1'b1);
        checkOutput("bp_release_gnt", 32'(gnt_o), 32'(4'b0100));
        checkResult("bp_release", 8'h03, 1'b0, 2'd0);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        checkResult("bp_second", 8'h30, 1'b0, 2'd1);
        nextCycle();
        checkResult("bp_third", 8'h0A, 1'b0, 2'd2);

        // Reset one cycle after a grant flushes the pipeline and the pointer.
        setOp(0, 8'h22, 8'h11, 1'b0);
        nextCycle();
        applyStimulus(4'b1111, 1'b1);
        checkOutput("mid_gnt", 32'(gnt_o), 32'(4'b1000));
        nextCycle();
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        checkOutput("mid_rst_gnt", 32'(gnt_o), 32'(4'b0000));
        nextCycle();
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b1);
        checkOutput("mid_after_gnt", 32'(gnt_o), 32'(4'b0001));
        checkOutput("mid_after_valid", 32'(res_valid_o), 32'(1'b0));
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("mid_flush_valid", 32'(res_valid_o), 32'(1'b0));
        nextCycle();
        checkResult("mid_new", 8'h33, 1'b0, 2'd0);

`ifdef RCA_ARB_OVF_EN
        // Signed overflow cases through requester 0.
        doReset();
        nextCycle();
        setOp(0, 8'h7F, 8'h01, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        nextCycle();
        checkResult("ovf_pos", 8'h80, 1'b0, 2'd0);
        checkOutput("ovf_pos_ovf", 32'(res_ovf_o), 32'(1'b1));
        setOp(0, 8'h80, 8'hFF, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        nextCycle();
        checkResult("ovf_neg", 8'h7F, 1'b1, 2'd0);
        checkOutput("ovf_neg_ovf", 32'(res_ovf_o), 32'(1'b1));
        setOp(0, 8'h01, 8'h01, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        nextCycle();
        checkResult("ovf_none", 8'h02, 1'b0, 2'd0);
        checkOutput("ovf_none_ovf", 32'(res_ovf_o), 32'(1'b0));
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/rca_arbiter.md
# rca_arbiter

Round-robin arbiter and two-stage pipeline that shares a single `RCA` instance of width `BITS` among `N_REQ` requesters. Each requester presents operands with a level request. The block grants one requester per cycle, registers the granted operands into the adder input stage and registers the adder output with the winner's ID. It sits between the requesting datapath blocks and the adder, and replaces per-client adders where area matters.

## Interface
- `BITS`, 8, operand/sum width; passed to the internal `RCA`.
- `N_REQ`, 4, number of requesters, legal range 2..8.
- `IDW`, `$clog2(N_REQ)`, derived; ID width; not overridden.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_i`  in  N_REQ  request per requester. Held high with operands stable until granted.
- `a_i`  in  N_REQ*BITS  operand A; requester k at `[k*BITS +: BITS]`.
- `b_i`  in  N_REQ*BITS  operand B, same packing.
- `cin_i`  in  N_REQ  carry-in per requester.
- `gnt_o`  out  N_REQ  one-hot, combinational. Operands of the granted requester are captured at the end of this cycle.
- `res_valid_o`  out  1  result register holds a valid result.
- `res_ready_i`  in  1  consumer accepts result when `res_valid_o & res_ready_i`.
- `res_sum_o`  out  BITS  registered sum.
- `res_cout_o`  out  1  registered carry-out.
- `res_id_o`  out  IDW  index of the requester that produced the result.

## Operation
- Pipeline advance: `adv = !res_valid_o | res_ready_i`. When `adv = 0`, every register holds its value and `gnt_o` is all zero.
- Stage 1 (operand register `s1_valid`, `s1_a`, `s1_b`, `s1_cin`, `s1_id`):
  - On `adv`, loads the granted requester's operands and sets `s1_valid = |gnt_o`.
  - A cycle with no grant loads a bubble (`s1_valid = 0`).
- Adder: one `RCA #(BITS)` instance, driven combinationally from stage 1.
- Stage 2 (result register):
  - On `adv`, loads `sum`, `cout` and `s1_id`; sets `res_valid_o = s1_valid`.
  - Bubbles pass through and clear `res_valid_o` once the old result is accepted.
- Arbitration:
  - Pointer `last` (IDW bits) holds the index of the most recent grant.
  - Search order is `last+1, last+2, … last+N_REQ`, wrapping mod N_REQ. The first requester with `req_i` high wins.
  - `last` updates only on a cycle where a grant is issued.
- Grant conditions: `gnt_o` is nonzero only when `adv & |req_i & !rst`. Exactly one bit is set.
- Requester protocol: a requester that still has `req_i` high in the cycle after its grant is treated as a new request with whatever operands it then presents.
- Reset values:
  - `last = N_REQ-1`, so requester 0 has top priority first.
  - `s1_valid = 0`, `res_valid_o = 0`, `res_sum_o = 0`, `res_cout_o = 0`, `res_id_o = 0`.
  - `gnt_o = 0` while `rst` is high.
- Reset mid-operation: in-flight stage-1 and stage-2 contents are discarded with no result emitted, and `last` returns to `N_REQ-1`.
- Arithmetic: sum is modulo 2^BITS. `res_cout_o` is the RCA carry out.

## Timing
- Latency: grant in cycle t puts the result on `res_valid_o` in cycle t+2, provided `res_ready_i` was high in cycles t and t+1.
- Throughput: one grant per cycle under continuous `res_ready_i = 1`.
- Backpressure: `res_valid_o = 1` with `res_ready_i = 0` freezes both stages and suppresses grants in the same cycle. Throughput resumes the cycle `res_ready_i` rises. Stage 1 stays valid during the freeze, with no loss and no duplication.
- `gnt_o` is a pure function of `req_i`, `last`, `adv` and `rst`, so there is a combinational path `res_ready_i` → `gnt_o`.
- Critical path: stage-1 register → RCA → stage-2 register.

## Configuration
- `RCA_ARB_OVF_EN` defined:
  - Adds output `res_ovf_o` (1 bit), the registered two's-complement overflow: `(s1_a[BITS-1] == s1_b[BITS-1]) & (sum[BITS-1] != s1_a[BITS-1])`.
  - Reset value 0; it follows the same stage-2 enable as `res_sum_o`.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then single request: `req_i=0001`, `a=8'h0F`, `b=8'h01`, `cin=0`. Expect `gnt_o=0001` in cycle 0, then in cycle 2 `res_valid_o=1`, `sum=8'h10`, `cout=0`, `id=0`.
- Carry-out: requester 2, `a=8'hFF`, `b=8'h01`, `cin=1`. Expect `sum=8'h01`, `cout=1`, `id=2`.
- Round-robin: all four `req_i` held high for 8 cycles with `res_ready_i=1`. Expect grants 0,1,2,3,0,1,2,3, one per cycle, and results with matching IDs in the same order two cycles later.
- Backpressure: two back-to-back grants, then `res_ready_i=0` for 3 cycles. Expect the first result held stable, `gnt_o=0` during the stall, and after release the second result following next cycle with no loss.
- Reset mid-operation: assert `rst` one cycle after a grant. Expect no `res_valid_o`, and the next grant with all requests high goes to requester 0.
- With `RCA_ARB_OVF_EN`: `a=8'h7F`, `b=8'h01` → `res_ovf_o=1`; `a=8'h80`, `b=8'hFF` → `res_ovf_o=1`, `cout=1`; `a=8'h01`, `b=8'h01` → `res_ovf_o=0`.
